multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Moore FSM that sequences the shared-memory multicycle MIPS datapath: fetch, decode, execute, memory, writeback.
//   Holds a wait-state handshake with unified instruction/data memory (mem_req/mem_ready) with timeout.
//   Sits beside the datapath and drives its mux selects, write strobes and ALU control; sole owner of the memory port.
// PARAMETERS
//   WAIT_MAX   15   max cycles a memory state waits for mem_ready before abort (1..255)
//   CNT_W      8    width of wait counter; must satisfy 2**CNT_W > WAIT_MAX
// PORTS
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   op           in   6  opcode from instruction register
//   funct        in   6  funct field from instruction register
//   mem_ready    in   1  memory completes current access this cycle
//   mem_req      out  1  memory access request (held until mem_ready or abort)
//   iord         out  1  address select: 0=PC, 1=ALUOut
//   irwrite      out  1  load instruction register
//   pcwrite      out  1  unconditional PC load
//   pcwrite_cond out  1  PC load if branch condition true (datapath evaluates)
//   ne           out  1  branch condition inverted (bne)
//   memwrite     out  1  memory write strobe
//   regwrite     out  1  register file write strobe
//   regdst       out  1  1=rd, 0=rt
//   memtoreg     out  1  writeback select: 1=MDR, 0=ALUOut
//   link         out  1  write PC+4 to $ra (jal)
//   alusrca      out  1  0=PC, 1=A
//   alusrcb      out  2  00=B, 01=const 4, 10=signext imm, 11=imm<<2
//   pcsrc        out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
//   aluop        out  4  ALU control, same encoding as the main decoder
//   size         out  2  load size for MDR extend: 00=word, 01=half, 10=byte, 11=byte unsigned
//   bus_err      out  1  one-cycle pulse on memory timeout
// BEHAVIOUR
//   Reset (reset=0, async): state<=FETCH, wait_cnt<=0; all strobes/outputs forced 0 combinationally while low.
//   Outputs are pure functions of state (plus op/funct in DECODE/IEXEC/EXEC/BRANCH). Unlisted outputs are 0.
//   FETCH:  mem_req, iord=0, alusrca=0, alusrcb=01, aluop=ADD; when mem_ready: irwrite=1, pcwrite=1, ->DECODE.
//   DECODE: alusrca=0, alusrcb=11, aluop=ADD. Next state from op:
//     lw/lh/lb/lbu/sw->MEMADR; op=0,funct=001000->JR; other op=0->EXEC; beq/bne/blez->BRANCH;
//     addi/ori/andi/xori/slti/lui->IEXEC; j->JUMP; jal->JAL; other op->illegal handling (see CONFIGURATION).
//   MEMADR: alusrca=1, alusrcb=10, ADD; ->MEMWR if sw, else ->MEMRD.
//   MEMRD:  mem_req, iord=1, size per op; on mem_ready ->MEMWB.  MEMWB: regwrite, memtoreg=1, regdst=0 ->FETCH.
//   MEMWR:  mem_req, iord=1, memwrite=1 (held until mem_ready); on mem_ready ->FETCH.
//   EXEC:   alusrca=1, alusrcb=00, aluop=RTYPE ->ALUWB: regwrite, regdst=1 ->FETCH.
//   IEXEC:  alusrca=1, alusrcb=10, aluop per opcode ->IWB: regwrite, regdst=0 ->FETCH.
//   BRANCH: alusrca=1, alusrcb=00, aluop SUB (beq/bne) or BLEZ, pcsrc=01, pcwrite_cond=1, ne=(op==bne) ->FETCH.
//   JUMP: pcsrc=10, pcwrite ->FETCH.  JAL: pcsrc=10, pcwrite, regwrite, link ->FETCH.  JR: pcsrc=11, pcwrite ->FETCH.
//   Latency with zero-wait memory: lw 5, sw 4, R/I-type 4, branch/jump 3 cycles; each wait cycle adds 1.
//   wait_cnt clears on entry to FETCH/MEMRD/MEMWR, increments each cycle there without mem_ready.
//   Timeout: wait_cnt==WAIT_MAX and mem_ready=0 -> bus_err pulse, mem_req drops, ->FETCH; no PC/IR/reg/mem commit.
//   mem_ready ignored outside memory states; mem_ready on the timeout cycle wins (normal completion).
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: illegal op -> TRAP state (absorbing, all strobes 0, illegal_op out=1) until reset.
//   ILLEGAL_TRAP_EN undefined: illegal op treated as NOP: DECODE->FETCH, no illegal_op port.
// STRUCTURE
//   mc_ctrl_pkg: state_t enum, opcode/funct localparams, aluop encodings, alusrcb/pcsrc/size encodings.
//   Sub-module mc_op_class: combinational op/funct -> {class, aluop, size, is_ne}; FSM consumes class.
// TESTING
//   Reset mid-MEMWR (reset low in wait cycle) -> memwrite/mem_req 0 immediately; FETCH after release.
//   add, mem_ready=1 always -> FETCH,DECODE,EXEC,ALUWB; regwrite+regdst=1 only in cycle 4.
//   lw, mem_ready delayed 3 cycles in MEMRD -> memtoreg+regwrite in cycle 8, iord=1 held 4 cycles.
//   FETCH with mem_ready=0 for 16 cycles (WAIT_MAX=15) -> bus_err one pulse, irwrite/pcwrite never 1, re-FETCH.
//   bne then jal then jr -> ne=1 with pcwrite_cond; link+pcsrc=10; pcsrc=11, each 3 cycles.
//   op=6'b111111 -> with ILLEGAL_TRAP_EN: TRAP, illegal_op=1 held; without: FETCH next cycle, no strobes.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode
// classes, MIPS opcode/funct values and datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_RTYPE, C_JR, C_BRANCH, C_IMM, C_J, C_JAL, C_ILLEGAL
  } opclass_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU control
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_LUI   = 4'd6;
  localparam logic [3:0] ALU_BLEZ  = 4'd7;
  localparam logic [3:0] ALU_RTYPE = 4'd8;

  // ALU B-source, PC-source and load-size selects
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_REG = 2'b11;
  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_BYTE   = 2'b10;
  localparam logic [1:0] SZ_BYTEU  = 2'b11;

endpackage

// File: rtl/multicycle_controller_op_class.sv
// mc_op_class: combinational instruction classifier. Maps op/funct to the
// class the FSM branches on, plus the ALU control and load size that the
// execute / memory states need.
module mc_op_class
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class,
  output logic [3:0] o_aluop,
  output logic [1:0] o_size,
  output logic       o_is_ne
);

  // classify opcode; unknown opcodes fall into the illegal class
  always_comb begin
    o_class = C_ILLEGAL;
    o_aluop = ALU_ADD;
    o_size  = SZ_WORD;
    o_is_ne = (i_op == OP_BNE);
    case (i_op)
      OP_LW:    o_class = C_LOAD;
      OP_LH:    begin o_class = C_LOAD; o_size = SZ_HALF;  end
      OP_LB:    begin o_class = C_LOAD; o_size = SZ_BYTE;  end
      OP_LBU:   begin o_class = C_LOAD; o_size = SZ_BYTEU; end
      OP_SW:    o_class = C_STORE;
      OP_RTYPE: o_class = (i_funct == FN_JR) ? C_JR : C_RTYPE;
      OP_BEQ,
      OP_BNE:   begin o_class = C_BRANCH; o_aluop = ALU_SUB;  end
      OP_BLEZ:  begin o_class = C_BRANCH; o_aluop = ALU_BLEZ; end
      OP_ADDI:  o_class = C_IMM;
      OP_ORI:   begin o_class = C_IMM; o_aluop = ALU_OR;  end
      OP_ANDI:  begin o_class = C_IMM; o_aluop = ALU_AND; end
      OP_XORI:  begin o_class = C_IMM; o_aluop = ALU_XOR; end
      OP_SLTI:  begin o_class = C_IMM; o_aluop = ALU_SLT; end
      OP_LUI:   begin o_class = C_IMM; o_aluop = ALU_LUI; end
      OP_J:     o_class = C_J;
      OP_JAL:   o_class = C_JAL;
      default:  o_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared-memory multicycle
// MIPS datapath, with a wait-state memory handshake and timeout abort.
// i_reset is asynchronous and active-low; all outputs read 0 while it is low.
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM in an
// absorbing TRAP state and raise o_illegal_op; otherwise they act as a NOP.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
)(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_iord,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_pcwrite_cond,
  output logic       o_ne,
  output logic       o_memwrite,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_link,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsrc,
  output logic [3:0] o_aluop,
  output logic [1:0] o_size,
`ifdef ILLEGAL_TRAP_EN
  output logic       o_illegal_op,
`endif
  output logic       o_bus_err
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [3:0]       w_class, w_aluop;
  logic [1:0]       w_size;
  logic             w_is_ne, w_mem_state, w_timeout;

  mc_op_class u_op_class (
    .i_op(i_op), .i_funct(i_funct),
    .o_class(w_class), .o_aluop(w_aluop), .o_size(w_size), .o_is_ne(w_is_ne)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  // mem_ready on the last allowed wait cycle still counts as completion
  assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == CNT_W'(WAIT_MAX));

  // next-state selection; a timeout always abandons the instruction
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (w_class)
          C_LOAD, C_STORE: w_next = S_MEMADR;
          C_JR:            w_next = S_JR;
          C_RTYPE:         w_next = S_EXEC;
          C_BRANCH:        w_next = S_BRANCH;
          C_IMM:           w_next = S_IEXEC;
          C_J:             w_next = S_JUMP;
          C_JAL:           w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:         w_next = S_TRAP;
`else
          default:         w_next = S_FETCH;
`endif
        endcase
      S_MEMADR: w_next = (w_class == C_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = i_mem_ready ? S_MEMWB : (w_timeout ? S_FETCH : S_MEMRD);
      S_MEMWR:  w_next = (i_mem_ready || w_timeout) ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // state register and wait counter; counter restarts on any state exit
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (w_mem_state && !i_mem_ready && !w_timeout) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  // output decode from state; everything held at 0 while reset is low
  always_comb begin
    o_mem_req = 1'b0; o_iord = 1'b0; o_irwrite = 1'b0; o_pcwrite = 1'b0;
    o_pcwrite_cond = 1'b0; o_ne = 1'b0; o_memwrite = 1'b0; o_regwrite = 1'b0;
    o_regdst = 1'b0; o_memtoreg = 1'b0; o_link = 1'b0; o_alusrca = 1'b0;
    o_alusrcb = SRCB_B; o_pcsrc = PCSRC_ALU; o_aluop = ALU_ADD; o_size = SZ_WORD;
`ifdef ILLEGAL_TRAP_EN
    o_illegal_op = 1'b0;
`endif
    o_bus_err = i_reset && w_timeout;
    if (i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req = !w_timeout; o_alusrcb = SRCB_FOUR;
          o_irwrite = i_mem_ready; o_pcwrite = i_mem_ready;
        end
        S_DECODE: o_alusrcb = SRCB_IMM2;
        S_MEMADR: begin o_alusrca = 1'b1; o_alusrcb = SRCB_IMM; end
        S_MEMRD:  begin o_mem_req = !w_timeout; o_iord = 1'b1; o_size = w_size; end
        S_MEMWB:  begin o_regwrite = 1'b1; o_memtoreg = 1'b1; end
        S_MEMWR:  begin o_mem_req = !w_timeout; o_iord = 1'b1; o_memwrite = !w_timeout; end
        S_EXEC:   begin o_alusrca = 1'b1; o_alusrcb = SRCB_B; o_aluop = ALU_RTYPE; end
        S_ALUWB:  begin o_regwrite = 1'b1; o_regdst = 1'b1; end
        S_IEXEC:  begin o_alusrca = 1'b1; o_alusrcb = SRCB_IMM; o_aluop = w_aluop; end
        S_IWB:    o_regwrite = 1'b1;
        S_BRANCH: begin
          o_alusrca = 1'b1; o_alusrcb = SRCB_B; o_aluop = w_aluop;
          o_pcsrc = PCSRC_OUT; o_pcwrite_cond = 1'b1; o_ne = w_is_ne;
        end
        S_JUMP:   begin o_pcsrc = PCSRC_JMP; o_pcwrite = 1'b1; end
        S_JAL:    begin o_pcsrc = PCSRC_JMP; o_pcwrite = 1'b1; o_regwrite = 1'b1; o_link = 1'b1; end
        S_JR:     begin o_pcsrc = PCSRC_REG; o_pcwrite = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   o_illegal_op = 1'b1;
`endif
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A transaction-level model
// expands each instruction (and its memory wait counts) into the expected
// per-cycle output trace and the mem_ready values to drive.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  localparam int WMAX = 15;

  logic       clk = 1'b0, rst = 1'b0, rdy = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       o_mem_req, o_iord, o_irwrite, o_pcwrite, o_pcwrite_cond, o_ne;
  logic       o_memwrite, o_regwrite, o_regdst, o_memtoreg, o_link, o_alusrca, o_bus_err;
  logic [1:0] o_alusrcb, o_pcsrc, o_size;
  logic [3:0] o_aluop;
`ifdef ILLEGAL_TRAP_EN
  logic       o_illegal_op;
`endif

  multicycle_controller #(.WAIT_MAX(WMAX), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_op(op), .i_funct(funct), .i_mem_ready(rdy),
    .o_mem_req(o_mem_req), .o_iord(o_iord), .o_irwrite(o_irwrite), .o_pcwrite(o_pcwrite),
    .o_pcwrite_cond(o_pcwrite_cond), .o_ne(o_ne), .o_memwrite(o_memwrite),
    .o_regwrite(o_regwrite), .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_link(o_link),
    .o_alusrca(o_alusrca), .o_alusrcb(o_alusrcb), .o_pcsrc(o_pcsrc), .o_aluop(o_aluop),
    .o_size(o_size),
`ifdef ILLEGAL_TRAP_EN
    .o_illegal_op(o_illegal_op),
`endif
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_req, iord, irwrite, pcwrite, pcwrite_cond, ne, memwrite;
    logic regwrite, regdst, memtoreg, link, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop;
    logic [1:0] size;
    logic bus_err;
  } ov_t;

  ov_t q_exp[$];
  bit  q_rdy[$];
  int  total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ov_t got_v();
    ov_t v;
    v.mem_req = o_mem_req; v.iord = o_iord; v.irwrite = o_irwrite; v.pcwrite = o_pcwrite;
    v.pcwrite_cond = o_pcwrite_cond; v.ne = o_ne; v.memwrite = o_memwrite;
    v.regwrite = o_regwrite; v.regdst = o_regdst; v.memtoreg = o_memtoreg; v.link = o_link;
    v.alusrca = o_alusrca; v.alusrcb = o_alusrcb; v.pcsrc = o_pcsrc; v.aluop = o_aluop;
    v.size = o_size; v.bus_err = o_bus_err;
    return v;
  endfunction

  task automatic push(input ov_t v, input bit r);
    q_exp.push_back(v); q_rdy.push_back(r);
  endtask

  // non-memory cycle: mem_ready must be ignored, so drive it randomly
  task automatic push_idle(input ov_t v);
    push(v, 1'($urandom_range(0, 1)));
  endtask

  // memory access taking 'waits' not-ready cycles; past WMAX it times out
  task automatic mem_access(input ov_t base, input ov_t done_v, input int waits, output bit ok);
    ov_t t;
    if (waits > WMAX) begin
      repeat (WMAX) push(base, 1'b0);
      t = base; t.mem_req = 1'b0; t.memwrite = 1'b0; t.bus_err = 1'b1;
      push(t, 1'b0);
      ok = 1'b0;
    end else begin
      repeat (waits) push(base, 1'b0);
      push(done_v, 1'b1);
      ok = 1'b1;
    end
  endtask

  // expected trace of one instruction: w1 = fetch waits, w2 = data access waits
  task automatic model(input logic [5:0] o, input logic [5:0] f, input int w1, input int w2);
    ov_t v, d;
    bit ok;
    v = '0; v.mem_req = 1; v.alusrcb = SRCB_FOUR; v.aluop = ALU_ADD;
    d = v; d.irwrite = 1; d.pcwrite = 1;
    mem_access(v, d, w1, ok);
    if (!ok) return;
    v = '0; v.alusrcb = SRCB_IMM2; v.aluop = ALU_ADD; push_idle(v);
    case (o)
      OP_LW, OP_LH, OP_LB, OP_LBU: begin
        v = '0; v.alusrca = 1; v.alusrcb = SRCB_IMM; push_idle(v);
        v = '0; v.mem_req = 1; v.iord = 1;
        v.size = (o == OP_LW) ? 2'b00 : (o == OP_LH) ? 2'b01 : (o == OP_LB) ? 2'b10 : 2'b11;
        mem_access(v, v, w2, ok);
        if (ok) begin v = '0; v.regwrite = 1; v.memtoreg = 1; push_idle(v); end
      end
      OP_SW: begin
        v = '0; v.alusrca = 1; v.alusrcb = SRCB_IMM; push_idle(v);
        v = '0; v.mem_req = 1; v.iord = 1; v.memwrite = 1;
        mem_access(v, v, w2, ok);
      end
      OP_RTYPE: begin
        if (f == FN_JR) begin v = '0; v.pcsrc = 2'b11; v.pcwrite = 1; push_idle(v); end
        else begin
          v = '0; v.alusrca = 1; v.alusrcb = SRCB_B; v.aluop = ALU_RTYPE; push_idle(v);
          v = '0; v.regwrite = 1; v.regdst = 1; push_idle(v);
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ: begin
        v = '0; v.alusrca = 1; v.alusrcb = SRCB_B; v.aluop = (o == OP_BLEZ) ? ALU_BLEZ : ALU_SUB;
        v.pcsrc = 2'b01; v.pcwrite_cond = 1; v.ne = (o == OP_BNE); push_idle(v);
      end
      OP_ADDI, OP_ORI, OP_ANDI, OP_XORI, OP_SLTI, OP_LUI: begin
        v = '0; v.alusrca = 1; v.alusrcb = SRCB_IMM;
        v.aluop = (o == OP_ADDI) ? ALU_ADD : (o == OP_ORI) ? ALU_OR : (o == OP_ANDI) ? ALU_AND :
                  (o == OP_XORI) ? ALU_XOR : (o == OP_SLTI) ? ALU_SLT : ALU_LUI;
        push_idle(v);
        v = '0; v.regwrite = 1; push_idle(v);
      end
      OP_J:   begin v = '0; v.pcsrc = 2'b10; v.pcwrite = 1; push_idle(v); end
      OP_JAL: begin v = '0; v.pcsrc = 2'b10; v.pcwrite = 1; v.regwrite = 1; v.link = 1; push_idle(v); end
      default: ; // illegal: no cycles beyond DECODE
    endcase
  endtask

  // play up to n queued cycles (n<0: all); inputs at posedge+1, check at negedge
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f, input int n);
    int k = 0;
    op = o; funct = f;
    while (q_exp.size() > 0 && (n < 0 || k < n)) begin
      ov_t e;
      rdy = q_rdy.pop_front();
      e = q_exp.pop_front();
      @(negedge clk);
      chk(tag, 32'(got_v()), 32'(e));
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input int w1, input int w2);
    model(o, f, w1, w2);
    run(tag, o, f, -1);
  endtask

  function automatic int pickw();
    int r = $urandom_range(0, 15);
    if (r == 0) return WMAX;
    if (r == 1) return WMAX + 1;
    if (r < 8)  return 0;
    return $urandom_range(1, 4);
  endfunction

  logic [5:0] ops [0:17] = '{OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW, OP_RTYPE, OP_RTYPE, OP_BEQ,
                             OP_BNE, OP_BLEZ, OP_ADDI, OP_ORI, OP_ANDI, OP_XORI, OP_SLTI,
                             OP_LUI, OP_J, OP_JAL};

  initial begin
    // reset state: everything 0 even with mem_ready high
    rdy = 1'b1;
    @(negedge clk);
    chk("reset_outs", 32'(got_v()), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    instr("add",        OP_RTYPE, 6'b100000, 0, 0);
    instr("lw_wait3",   OP_LW,    6'h0,      0, 3);
    instr("fetch_tmo",  OP_RTYPE, 6'b100000, WMAX + 1, 0);
    instr("fetch_edge", OP_ADDI,  6'h0,      WMAX, 0);
    instr("bne",        OP_BNE,   6'h0,      0, 0);
    instr("jal",        OP_JAL,   6'h0,      0, 0);
    instr("jr",         OP_RTYPE, FN_JR,     0, 0);
    instr("lbu_tmo",    OP_LBU,   6'h0,      1, WMAX + 1);
    instr("sw_edge",    OP_SW,    6'h0,      0, WMAX);

    // async reset while MEMWR waits: strobes drop at once, FETCH afterwards
    model(OP_SW, 6'h0, 0, 5);
    run("sw_pre_rst", OP_SW, 6'h0, 4);
    rdy = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_memwrite", 32'(o_memwrite), 32'h0);
    chk("rst_mem_req", 32'(o_mem_req), 32'h0);
    q_exp.delete(); q_rdy.delete();
    @(posedge clk); #1 rst = 1'b1;
    instr("after_rst", OP_LH, 6'h0, 0, 1);

`ifndef ILLEGAL_TRAP_EN
    instr("illegal_nop", 6'b111111, 6'h0, 0, 0);
    instr("post_nop",    OP_J,      6'h0, 0, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      int idx = $urandom_range(0, 19);
      logic [5:0] o, f;
      f = 6'($urandom_range(0, 63));
      if (idx >= 18) o = 6'b111111 - 6'(idx - 18);
      else o = ops[idx];
      if (o == OP_RTYPE && $urandom_range(0, 3) == 0) f = FN_JR;
`ifdef ILLEGAL_TRAP_EN
      if (idx >= 18) o = OP_J;
`endif
      instr("rand", o, f, pickw(), pickw());
    end

`ifdef ILLEGAL_TRAP_EN
    // illegal op parks in TRAP until reset
    model(6'b111111, 6'h0, 0, 0);
    run("trap_entry", 6'b111111, 6'h0, -1);
    for (int i = 0; i < 4; i++) begin
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("trap_outs", 32'(got_v()), 32'h0);
      chk("trap_flag", 32'(o_illegal_op), 32'h1);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1 chk("trap_rst", 32'(o_illegal_op), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    instr("post_trap", OP_ADDI, 6'h0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
